// File: rtl/debug_bus_pkg.sv
// Shared types and helpers for the debug bus responder: FSM states, the
// captured request used for stability checking, and the address decode.
package debug_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2
  } state_e;

  // Every field that must hold still between req rising and gnt.
  typedef struct packed {
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  typedef struct packed {
    logic        inRange;
    logic [31:0] index;
  } addr_check_t;

  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hBADC_AB1E;

  // Decodes a byte address against the memory window. Arithmetic is plain
  // 32-bit unsigned, so addresses below the base wrap to a huge offset and
  // fail the word-count comparison as well as the base comparison.
  function automatic addr_check_t check_addr(input logic [31:0] add,
                                             input logic [31:0] base,
                                             input logic [31:0] words);
    addr_check_t res;
    logic [31:0] offset;
    offset      = add - base;
    res.index   = offset >> 2;
    res.inRange = (add >= base) && (res.index < words);
    return res;
  endfunction

endpackage

// File: rtl/debug_bus_mem.sv
// Single-port word memory with per-byte write enables and a registered read.
// Contents and the read register are deliberately left unreset.
module debug_bus_mem #(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input  logic          clk_i,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [WORDS];
  logic [31:0] r_rdata;

  // Byte-enabled write or word read; the read register holds between reads.
  always_ff @(posedge clk_i) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (i_be[b]) begin
            r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/debug_bus_responder.sv
// Target end of the debug bus: grants requests after a fixed number of wait
// states, services them from a local word memory, answers every grant one
// cycle later and flags out-of-range accesses and unstable requests.
module debug_bus_responder
  import debug_bus_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h1C00_0000,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned GNT_WAIT  = 0,
  parameter logic [31:0] ERR_RDATA = DEFAULT_ERR_RDATA
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        debug_req_i,
  input  logic [31:0] debug_add_i,
  input  logic        debug_wen_i,
  input  logic [31:0] debug_wdata_i,
  input  logic [3:0]  debug_be_i,
  output logic        debug_gnt_o,
  output logic [31:0] debug_rdata_o,
  output logic        debug_r_valid_o,
  output logic        debug_r_err_o,
  output logic        proto_err_o,
  output logic [15:0] wr_count_o,
  output logic [15:0] rd_count_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  addr_check_t w_check;
  logic        w_inRange;
  logic        w_gnt;
  logic        w_violation;
  logic [31:0] w_memRdata;

  logic        r_rvalid;
  logic        r_rerr;
  logic [31:0] r_rdata;
  logic        r_fromMem;
  logic        r_protoErr;
  logic [15:0] r_wrCount;
  logic [15:0] r_rdCount;

  assign w_check = check_addr(debug_add_i, ADDR_BASE, 32'(MEM_WORDS));

  // An in-range index always has its bits above the memory width clear;
  // requiring that here keeps the truncation to AW bits visibly safe.
  assign w_inRange = w_check.inRange && (w_check.index[31:AW] == '0);

  if (GNT_WAIT == 0) begin : gNoWait

    // Zero wait states: grant follows req directly and nothing can go unstable.
    always_comb begin
      w_gnt       = debug_req_i && !rst_i;
      w_violation = 1'b0;
    end

  end else begin : gWaitFsm

    localparam logic [3:0] WAIT_LOAD = 4'(GNT_WAIT - 1);

    state_e     r_state;
    logic [3:0] r_waitCnt;
    req_t       r_held;
    req_t       w_cur;
    logic       w_stable;

    assign w_cur = '{add: debug_add_i, wen: debug_wen_i,
                     wdata: debug_wdata_i, be: debug_be_i};

    // Grant only a request that is still present and unchanged; anything
    // else while waiting or granting is a violation.
    always_comb begin
      w_stable    = debug_req_i && (w_cur == r_held);
      w_gnt       = 1'b0;
      w_violation = 1'b0;
      case (r_state)
        WAIT: begin
          w_violation = !w_stable;
        end
        GRANT: begin
          w_gnt       = w_stable;
          w_violation = !w_stable;
        end
        default: begin
        end
      endcase
    end

    // Wait-state sequencer: capture the request, count down, grant once.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_state   <= IDLE;
        r_waitCnt <= '0;
        r_held    <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (debug_req_i) begin
              r_held    <= w_cur;
              r_waitCnt <= WAIT_LOAD;
              r_state   <= (GNT_WAIT == 1) ? GRANT : WAIT;
            end
          end
          WAIT: begin
            if (w_violation) begin
              r_state <= IDLE;
            end else begin
              r_waitCnt <= r_waitCnt - 4'd1;
              if (r_waitCnt <= 4'd1) begin
                r_state <= GRANT;
              end
            end
          end
          GRANT: begin
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end

  end

  debug_bus_mem #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) uMem (
    .clk_i   (clk_i),
    .i_en    (w_gnt && w_inRange),
    .i_we    (!debug_wen_i),
    .i_be    (debug_be_i),
    .i_addr  (w_check.index[AW-1:0]),
    .i_wdata (debug_wdata_i),
    .o_rdata (w_memRdata)
  );

  // Response stage, access counters and the sticky protocol flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid   <= 1'b0;
      r_rerr     <= 1'b0;
      r_rdata    <= '0;
      r_fromMem  <= 1'b0;
      r_protoErr <= 1'b0;
      r_wrCount  <= '0;
      r_rdCount  <= '0;
    end else begin
      r_rvalid <= w_gnt;
      if (w_violation) begin
        r_protoErr <= 1'b1;
      end
      if (w_gnt) begin
        r_rerr    <= !w_inRange;
        r_fromMem <= w_inRange && debug_wen_i;
        r_rdata   <= (!w_inRange && debug_wen_i) ? ERR_RDATA : 32'd0;
        if (w_inRange) begin
          if (debug_wen_i) begin
            r_rdCount <= r_rdCount + 16'd1;
          end else begin
            r_wrCount <= r_wrCount + 16'd1;
          end
        end
      end
    end
  end

  assign debug_gnt_o     = w_gnt;
  assign debug_r_valid_o = r_rvalid;
  assign debug_r_err_o   = r_rerr;
  assign debug_rdata_o   = r_fromMem ? w_memRdata : r_rdata;
  assign proto_err_o     = r_protoErr;
  assign wr_count_o      = r_wrCount;
  assign rd_count_o      = r_rdCount;

endmodule

// File: doc/debug_bus_responder.md
Name: debug_bus_responder

Overview:
- Target end of the debug bus: accepts word accesses on the req/gnt/r_valid protocol and services them from a local byte-enabled word memory.
- Used as the bench-side memory model that loaders and initiators write into and read back from.
- Inserts a configurable number of grant wait states, returns one response per granted request, and flags out-of-range accesses and protocol violations.

Parameters:
- ADDR_BASE, 32'h1C00_0000, byte address of memory word 0.
- MEM_WORDS, 1024, number of 32-bit words; power of two, at least 2.
- GNT_WAIT, 0, cycles req must be held before gnt; range 0..15.
- ERR_RDATA, 32'hBADC_AB1E, rdata returned for out-of-range reads.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- debug_req_i  in  1  request valid.
- debug_add_i  in  32  byte address; bits [1:0] ignored.
- debug_wen_i  in  1  1 = read, 0 = write.
- debug_wdata_i  in  32  write data.
- debug_be_i  in  4  byte enables; bit n selects byte n.
- debug_gnt_o  out  1  request accepted this cycle.
- debug_rdata_o  out  32  read data, valid with r_valid.
- debug_r_valid_o  out  1  response strobe.
- debug_r_err_o  out  1  response is for an out-of-range access.
- proto_err_o  out  1  sticky protocol-violation flag.
- wr_count_o  out  16  granted in-range writes, wraps.
- rd_count_o  out  16  granted in-range reads, wraps.

Behaviour:
- Reset values: gnt 0, r_valid 0, r_err 0, rdata 0, proto_err 0, both counters 0, FSM in IDLE, wait counter 0. Memory contents are not reset.
- In range: ADDR_BASE <= add < ADDR_BASE + 4*MEM_WORDS. Word index = (add - ADDR_BASE) >> 2, computed in 32-bit unsigned.
- GNT_WAIT = 0: gnt = req, combinational, in the same cycle. Back-to-back requests get one grant per cycle.
- GNT_WAIT > 0, FSM IDLE -> WAIT -> GRANT:
  - IDLE: req=1 loads the counter with GNT_WAIT-1 and moves to WAIT (or to GRANT if GNT_WAIT=1).
  - WAIT: counter decrements each cycle; at 0 the next state is GRANT.
  - GRANT: gnt=1 combinationally while req=1. Returns to IDLE in the following cycle, so a held req restarts the wait.
  - Result: gnt asserts exactly GNT_WAIT cycles after req first rises.
- Protocol rule: after req rises, req, add, wen, wdata and be must stay stable until gnt.
  - req falling before gnt, or any stable field changing before gnt, sets proto_err_o (sticky until reset) and returns the FSM to IDLE.
  - The aborted request gets no response.
- Memory access happens in the grant cycle:
  - In-range write: only bytes with be=1 are updated at the clock edge.
  - In-range read: the word is sampled at the clock edge.
  - be=0000 write: no update, but still counted and still answered.
- Response: exactly one cycle after each grant cycle, r_valid=1 for one cycle.
  - rdata = read word for a read, 0 for a write.
  - r_err = 0 for in range.
  - r_valid=0 in cycles not following a grant; rdata and r_err hold their last value.
  - Throughput is one response per cycle with no stalls. No response backpressure exists.
- Out of range: still granted with the same timing, no memory update, no counter increment. Response carries r_err=1, and rdata = ERR_RDATA for reads or 0 for writes.
- Read-after-write to the same word in consecutive grants returns the new data; no bypass needed given the one-cycle latency.
- Counters wrap from 16'hFFFF to 0.
- Reset asserted mid-transaction: gnt and r_valid drop asynchronously, the pending response is discarded, and the FSM returns to IDLE. A memory write in that cycle may or may not complete.

Decomposition:
- Package debug_bus_pkg holds:
  - state enum {IDLE, WAIT, GRANT};
  - a request struct {add, wen, wdata, be} used for the stability check;
  - the default ERR_RDATA constant;
  - a function returning in-range status and word index.
- One sub-module, debug_bus_mem: a MEM_WORDS x 32 array with a single port, byte-enabled write and registered read. It has no reset.

Test Plan:
- Write then read, GNT_WAIT=0: write 0xDEADBEEF to ADDR_BASE+8, then read it -> gnt in the same cycle; r_valid one cycle later; rdata=0xDEADBEEF; wr_count=1, rd_count=1.
- Byte enables: write 0x11223344 with be=1111, then 0xAABBCCDD with be=0101, then read -> rdata=0x11BB33DD.
- Wait states, GNT_WAIT=3: hold a read req -> gnt exactly 3 cycles after req rises, r_valid at cycle 4, no proto_err.
- Out of range: read ADDR_BASE+4*MEM_WORDS -> r_err=1, rdata=0xBADCAB1E, rd_count unchanged. Read ADDR_BASE-4 -> same result.
- Violation, GNT_WAIT=2: change add after one cycle of req -> proto_err=1 (sticky), no r_valid. A following legal access still completes normally.
- Streaming plus reset, GNT_WAIT=0: 8 back-to-back writes and reads -> 8 consecutive r_valid pulses with correct data. Assert rst_i during a read grant -> r_valid=0, counters=0.
